// File: rtl/csc_pkg.sv
// csc_pkg: shared widths, types and helpers for the csc_core colour-space converter.
// Optional rounding is selected in csc_core by the CSC_ROUND_EN macro.
package csc_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int COEF_WIDTH     = 10;
  localparam int COEF_FRAC      = 8;
  localparam int CLIP_CNT_WIDTH = 16;

  // Signed coef x zero-extended pixel, and a three-term sum plus shifted bias.
  localparam int PROD_WIDTH = COEF_WIDTH + DATA_WIDTH + 1;
  localparam int SUM_WIDTH  = PROD_WIDTH + 3;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;
  typedef logic [DATA_WIDTH-1:0]        pix_t;

  // Element [row][col] sits at bit (row*3+col)*COEF_WIDTH; row 0 produces red.
  typedef coef_t [2:0][2:0] coef_mat_t;
  typedef pix_t  [2:0]      bias_vec_t;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

  localparam coef_t COEF_ONE  = coef_t'(1 << COEF_FRAC);
  localparam coef_t COEF_ZERO = '0;

  localparam coef_mat_t COEF_IDENTITY = {COEF_ONE,  COEF_ZERO, COEF_ZERO,
                                         COEF_ZERO, COEF_ONE,  COEF_ZERO,
                                         COEF_ZERO, COEF_ZERO, COEF_ONE};

  localparam logic signed [SUM_WIDTH-1:0] SUM_PIX_MAX = SUM_WIDTH'((1 << DATA_WIDTH) - 1);

  // Saturate a scaled signed sum into the unsigned pixel range.
  function automatic pix_t clip_pix(input logic signed [SUM_WIDTH-1:0] v);
    if (v[SUM_WIDTH-1])        return '0;
    else if (v > SUM_PIX_MAX)  return '1;
    else                       return v[DATA_WIDTH-1:0];
  endfunction

  // True when clip_pix would have to saturate this value.
  function automatic logic is_clipped(input logic signed [SUM_WIDTH-1:0] v);
    return v[SUM_WIDTH-1] || (v > SUM_PIX_MAX);
  endfunction

endpackage

// File: rtl/csc_row_mac.sv
// csc_row_mac: one output row of the 3x3 matrix. Stage 1 registers three
// signed products and the row bias; stage 2 registers their sum plus the
// bias scaled into the coefficient fixed-point domain.
module csc_row_mac import csc_pkg::*; (
  input  logic                        clk,
  input  logic                        rst,
  input  pix_t [2:0]                  i_pix,
  input  coef_t [2:0]                 i_coef,
  input  pix_t                        i_bias,
  output logic signed [SUM_WIDTH-1:0] o_sum
);

  logic [2:0][PROD_WIDTH-1:0]  prod_d, prod_q;
  pix_t                        bias_d, bias_q;
  logic signed [SUM_WIDTH-1:0] sum_d, sum_q;

  // Stage 1: low PROD_WIDTH bits of the product are the exact signed result.
  always_comb begin
    prod_d = '0;
    bias_d = i_bias;
    for (int c = 0; c < 3; c++) begin
      prod_d[c] = PROD_WIDTH'($signed(i_coef[c])) * PROD_WIDTH'(i_pix[c]);
    end
  end

  // Stage 2: sign-extend the products and add the bias aligned to COEF_FRAC.
  always_comb begin
    sum_d = SUM_WIDTH'($signed(prod_q[0])) + SUM_WIDTH'($signed(prod_q[1]))
          + SUM_WIDTH'($signed(prod_q[2])) + SUM_WIDTH'({bias_q, {COEF_FRAC{1'b0}}});
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      bias_q <= '0;
      sum_q  <= '0;
    end else begin
      prod_q <= prod_d;
      bias_q <= bias_d;
      sum_q  <= sum_d;
    end
  end

  assign o_sum = sum_q;

endmodule

// File: rtl/csc_core.sv
// csc_core: 3-stage pipelined 3x3 colour-space converter with frame-start
// shadowed coefficients/bias/bypass and a per-frame clip counter.
// Macro CSC_ROUND_EN: round half up before the final shift; otherwise floor.
// Stream has no back-pressure: one pixel per clock in, one out 3 clocks later.
module csc_core import csc_pkg::*; (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_vs,
  input  logic                        i_hs,
  input  logic                        i_de,
  input  logic [DATA_WIDTH-1:0]       i_r,
  input  logic [DATA_WIDTH-1:0]       i_g,
  input  logic [DATA_WIDTH-1:0]       i_b,
  input  logic [9*COEF_WIDTH-1:0]     i_coef,
  input  logic [3*DATA_WIDTH-1:0]     i_bias,
  input  logic                        i_bypass,
  output logic                        o_vs,
  output logic                        o_hs,
  output logic                        o_de,
  output logic [DATA_WIDTH-1:0]       o_r,
  output logic [DATA_WIDTH-1:0]       o_g,
  output logic [DATA_WIDTH-1:0]       o_b,
  output logic [CLIP_CNT_WIDTH-1:0]   o_clip_cnt
);

  logic                             vs_q, vs_rise;
  coef_mat_t                        coef_sh_d, coef_sh_q;
  bias_vec_t                        bias_sh_d, bias_sh_q;
  logic                             byp_sh_d, byp_sh_q;
  sync_t                            sync1_d, sync1_q, sync2_d, sync2_q, sync3_d, sync3_q;
  pix_t [2:0]                       pix_in, pix1_d, pix1_q, pix2_d, pix2_q, out_d, out_q;
  logic                             byp1_d, byp1_q, byp2_d, byp2_q;
  logic [2:0][SUM_WIDTH-1:0]        row_sum;
  logic [1:0]                       n_clip;
  logic [CLIP_CNT_WIDTH-1:0]        work_d, work_q, clip_cnt_d, clip_cnt_q, clip_base;
  logic [CLIP_CNT_WIDTH:0]          clip_sum;

  assign vs_rise = i_vs & ~vs_q;
  assign pix_in  = {i_b, i_g, i_r};

  // Drop the fractional bits of a row sum, optionally rounding half up first.
  function automatic logic signed [SUM_WIDTH-1:0] scale_sum(input logic signed [SUM_WIDTH-1:0] s);
`ifdef CSC_ROUND_EN
    return (s + SUM_WIDTH'(1 << (COEF_FRAC - 1))) >>> COEF_FRAC;
`else
    return s >>> COEF_FRAC;
`endif
  endfunction

  // Shadows reload only in the cycle where i_vs first goes high.
  always_comb begin
    coef_sh_d = coef_sh_q;
    bias_sh_d = bias_sh_q;
    byp_sh_d  = byp_sh_q;
    if (vs_rise) begin
      coef_sh_d = i_coef;
      bias_sh_d = i_bias;
      byp_sh_d  = i_bypass;
    end
  end

  genvar row;
  generate
    for (row = 0; row < 3; row++) begin : g_row
      csc_row_mac u_row_mac (
        .clk    (clk),
        .rst    (rst),
        .i_pix  (pix_in),
        .i_coef (coef_sh_q[row]),
        .i_bias (bias_sh_q[row]),
        .o_sum  (row_sum[row])
      );
    end
  endgenerate

  // Delay syncs, raw pixel and the bypass select alongside the MAC stages.
  always_comb begin
    sync1_d = '{vs: i_vs, hs: i_hs, de: i_de};
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    pix1_d  = pix_in;
    pix2_d  = pix1_q;
    byp1_d  = byp_sh_q;
    byp2_d  = byp1_q;
  end

  // Stage 3: scale, clip, bypass mux and blanking; clips count only on the
  // converted path while the pixel is active.
  always_comb begin
    out_d  = '0;
    n_clip = '0;
    for (int ch = 0; ch < 3; ch++) begin
      if (sync2_q.de) begin
        out_d[ch] = byp2_q ? pix2_q[ch] : clip_pix(scale_sum($signed(row_sum[ch])));
        if (!byp2_q && is_clipped(scale_sum($signed(row_sum[ch])))) begin
          n_clip = n_clip + 2'd1;
        end
      end
    end
  end

  // Frame start publishes the working count; same-cycle clips open the new frame.
  always_comb begin
    clip_base  = vs_rise ? '0 : work_q;
    clip_sum   = {1'b0, clip_base} + (CLIP_CNT_WIDTH+1)'(n_clip);
    work_d     = clip_sum[CLIP_CNT_WIDTH] ? '1 : clip_sum[CLIP_CNT_WIDTH-1:0];
    clip_cnt_d = vs_rise ? work_q : clip_cnt_q;
  end

  // All state registers, cleared asynchronously; shadows reset to identity/bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q       <= 1'b0;
      coef_sh_q  <= COEF_IDENTITY;
      bias_sh_q  <= '0;
      byp_sh_q   <= 1'b1;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      pix1_q     <= '0;
      pix2_q     <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      out_q      <= '0;
      work_q     <= '0;
      clip_cnt_q <= '0;
    end else begin
      vs_q       <= i_vs;
      coef_sh_q  <= coef_sh_d;
      bias_sh_q  <= bias_sh_d;
      byp_sh_q   <= byp_sh_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      pix1_q     <= pix1_d;
      pix2_q     <= pix2_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      out_q      <= out_d;
      work_q     <= work_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign o_vs       = sync3_q.vs;
  assign o_hs       = sync3_q.hs;
  assign o_de       = sync3_q.de;
  assign o_r        = out_q[0];
  assign o_g        = out_q[1];
  assign o_b        = out_q[2];
  assign o_clip_cnt = clip_cnt_q;

endmodule

// File: tb/tb_csc_core.sv
// tb_csc_core: table vectors plus hand sequences for csc_core, checked
// through an expected-output queue fed by an arithmetic reference model.
module tb_csc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vs, i_hs, i_de;
  logic [7:0]  i_r, i_g, i_b;
  logic [89:0] i_coef;
  logic [23:0] i_bias;
  logic        i_bypass;
  logic        o_vs, o_hs, o_de;
  logic [7:0]  o_r, o_g, o_b;
  logic [15:0] o_clip_cnt;

  int total = 0;
  int bad   = 0;

  csc_core dut (
    .clk(clk), .rst(rst),
    .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_coef(i_coef), .i_bias(i_bias), .i_bypass(i_bypass),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_clip_cnt(o_clip_cnt)
  );

  // clock
  always #5 clk = ~clk;

`ifdef CSC_ROUND_EN
  localparam int HALF_R = 2;
`else
  localparam int HALF_R = 1;
`endif

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] ncl;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];

  // reference model state
  logic [89:0] m_coef;
  logic [23:0] m_bias;
  logic        m_byp;
  logic        m_prev_vs;
  int          m_work;
  int          m_cnt;

  typedef struct packed {
    logic [89:0] coef;
    logic [23:0] bias;
    logic        byp;
    logic [23:0] pix;
    logic [23:0] expv;
    logic [1:0]  ncl;
  } vec_t;
  vec_t tab[7];

  function automatic logic [89:0] mk_coef(input int a0, a1, a2, b0, b1, b2, c0, c1, c2);
    logic [89:0] m;
    int v[9];
    v = '{a0, a1, a2, b0, b1, b2, c0, c1, c2};
    m = '0;
    for (int k = 0; k < 9; k++) m[k*10 +: 10] = 10'(v[k]);
    return m;
  endfunction

  function automatic logic [23:0] rgb(input int r, input int g, input int b);
    return {8'(b), 8'(g), 8'(r)};
  endfunction

  // One output channel: matrix row dot pixel, plus bias, scaled to integer.
  function automatic int conv(input int row, input logic [7:0] r, g, b);
    logic signed [9:0] c0, c1, c2;
    int s;
    c0 = m_coef[(row*3+0)*10 +: 10];
    c1 = m_coef[(row*3+1)*10 +: 10];
    c2 = m_coef[(row*3+2)*10 +: 10];
    s = int'(c0) * int'(r) + int'(c1) * int'(g) + int'(c2) * int'(b);
    s = s + int'(m_bias[row*8 +: 8]) * 256;
`ifdef CSC_ROUND_EN
    s = s + 128;
`endif
    return s >>> 8;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z = '0;
    m_coef    = mk_coef(256, 0, 0, 0, 256, 0, 0, 0, 256);
    m_bias    = '0;
    m_byp     = 1'b1;
    m_prev_vs = 1'b0;
    m_work    = 0;
    m_cnt     = 0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // driver: apply one input cycle, push its expectation, clock, compare the
  // output that leaves the pipeline on this edge
  task automatic cycle(input logic vs, hs, de, input logic [7:0] r, g, b,
                       input bit use_tab, input logic [23:0] tab_rgb);
    exp_t e, head;
    logic [7:0] o3[3];
    int s;
    bit rise;
    i_vs = vs; i_hs = hs; i_de = de; i_r = r; i_g = g; i_b = b;
    rise = vs && !m_prev_vs;
    e = '0;
    e.vs = vs; e.hs = hs; e.de = de;
    if (de) begin
      if (m_byp) begin
        o3[0] = r; o3[1] = g; o3[2] = b;
      end else begin
        for (int ch = 0; ch < 3; ch++) begin
          s = conv(ch, r, g, b);
          if (s < 0) begin
            o3[ch] = 8'd0; e.ncl = e.ncl + 2'd1;
          end else if (s > 255) begin
            o3[ch] = 8'd255; e.ncl = e.ncl + 2'd1;
          end else begin
            o3[ch] = 8'(s);
          end
        end
      end
      e.r = o3[0]; e.g = o3[1]; e.b = o3[2];
      if (use_tab) {e.b, e.g, e.r} = tab_rgb;
    end
    exp_q.push_back(e);
    head = exp_q[0];
    if (rise) begin
      m_cnt  = m_work;
      m_work = int'(head.ncl);
    end else begin
      m_work = m_work + int'(head.ncl);
    end
    if (m_work > 65535) m_work = 65535;
    if (rise) begin
      m_coef = i_coef; m_bias = i_bias; m_byp = i_bypass;
    end
    m_prev_vs = vs;
    @(posedge clk);
    #1;
    head = exp_q.pop_front();
    check("pix", 32'({o_vs, o_hs, o_de, o_b, o_g, o_r}),
          32'({head.vs, head.hs, head.de, head.b, head.g, head.r}));
    check("clip_cnt", 32'(o_clip_cnt), 32'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 24'd0);
  endtask

  task automatic px(input logic vs, input int r, g, b, input bit use_tab, input logic [23:0] ex);
    cycle(vs, 0, 1, 8'(r), 8'(g), 8'(b), use_tab, ex);
  endtask

  logic [89:0] ident, swap1, swap2;

  initial begin
    ident = mk_coef(256, 0, 0, 0, 256, 0, 0, 0, 256);
    swap1 = mk_coef(0, 256, 0, 0, 0, 256, 256, 0, 0);
    swap2 = mk_coef(0, 0, 256, 256, 0, 0, 0, 256, 0);

    tab[0] = '{ident, 24'd0, 1'b0, rgb(10, 128, 255), rgb(10, 128, 255), 2'd0};
    tab[1] = '{ident, rgb(200, 0, 0), 1'b0, rgb(100, 20, 30), rgb(255, 20, 30), 2'd1};
    tab[2] = '{mk_coef(-256, 0, 0, 0, 256, 0, 0, 0, 256), 24'd0, 1'b0,
               rgb(50, 60, 70), rgb(0, 60, 70), 2'd1};
    tab[3] = '{mk_coef(128, 0, 0, 0, 256, 0, 0, 0, 256), 24'd0, 1'b0,
               rgb(3, 4, 5), rgb(HALF_R, 4, 5), 2'd0};
    tab[4] = '{mk_coef(77, 150, 29, -43, -85, 128, 128, -107, -21), rgb(0, 128, 128), 1'b0,
               rgb(200, 100, 50), rgb(124, 86, 182), 2'd0};
    tab[5] = '{mk_coef(511, 511, 511, 511, 511, 511, 511, 511, 511), 24'hFFFFFF, 1'b1,
               rgb(1, 2, 3), rgb(1, 2, 3), 2'd0};
    tab[6] = '{mk_coef(511, 511, 511, -512, -512, -512, 0, 0, 256), 24'd0, 1'b0,
               rgb(255, 255, 255), rgb(255, 0, 255), 2'd2};

    // reset
    rst = 1'b1;
    i_vs = 0; i_hs = 0; i_de = 0; i_r = 0; i_g = 0; i_b = 0;
    i_coef = '0; i_bias = '0; i_bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'({o_vs, o_hs, o_de, o_b, o_g, o_r}), 32'd0);
    check("reset_clip_cnt", 32'(o_clip_cnt), 32'd0);
    rst = 1'b0;
    model_reset();

    // table vectors: one frame per vector, clip count checked at next frame start
    for (int i = 0; i < 7; i++) begin
      i_coef = tab[i].coef; i_bias = tab[i].bias; i_bypass = tab[i].byp;
      idle(0);
      cycle(1, 0, 0, 8'd0, 8'd0, 8'd0, 0, 24'd0);
      if (i > 0) check("tab_clip_cnt", 32'(o_clip_cnt), 32'(tab[i-1].ncl));
      idle(1);
      cycle(0, 1, 1, tab[i].pix[7:0], tab[i].pix[15:8], tab[i].pix[23:16], 1, tab[i].expv);
      idle(3);
    end
    cycle(1, 0, 0, 8'd0, 8'd0, 8'd0, 0, 24'd0);
    check("tab_clip_cnt", 32'(o_clip_cnt), 32'(tab[6].ncl));
    idle(2);

    // shadow timing: mid-frame coef change waits for the next vs rise
    i_coef = ident; i_bias = '0; i_bypass = 1'b0;
    cycle(1, 0, 0, 8'd0, 8'd0, 8'd0, 0, 24'd0);
    idle(1);
    for (int k = 0; k < 4; k++) px(0, 11, 22, 33, 1, rgb(11, 22, 33));
    i_coef = swap1;
    for (int k = 0; k < 3; k++) px(0, 11, 22, 33, 1, rgb(11, 22, 33));
    px(1, 11, 22, 33, 1, rgb(11, 22, 33));
    px(1, 11, 22, 33, 1, rgb(22, 33, 11));
    // vs held high: no further load even though i_coef moves
    i_coef = ident;
    for (int k = 0; k < 5; k++) px(1, 11, 22, 33, 1, rgb(22, 33, 11));
    px(0, 11, 22, 33, 1, rgb(22, 33, 11));
    // two rises two cycles apart both load
    i_coef = ident;
    px(1, 11, 22, 33, 1, rgb(22, 33, 11));
    px(0, 11, 22, 33, 1, rgb(11, 22, 33));
    i_coef = swap2;
    px(1, 11, 22, 33, 1, rgb(11, 22, 33));
    px(0, 11, 22, 33, 1, rgb(33, 11, 22));
    idle(3);

    // bypass over a full line with random matrix and bias
    for (int k = 0; k < 9; k++) i_coef[k*10 +: 10] = 10'($urandom_range(0, 1023));
    i_bias = 24'($urandom);
    i_bypass = 1'b1;
    cycle(1, 0, 0, 8'd0, 8'd0, 8'd0, 0, 24'd0);
    idle(1);
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 8'd0, 8'd0, 8'd0, 0, 24'd0);
    for (int k = 0; k < 1920; k++)
      cycle(0, 0, 1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 0, 24'd0);
    idle(4);

    // clipping frame, then reset in the middle of an active line
    i_coef = ident; i_bias = rgb(200, 0, 0); i_bypass = 1'b0;
    cycle(1, 0, 0, 8'd0, 8'd0, 8'd0, 0, 24'd0);
    idle(1);
    px(0, 100, 0, 0, 1, rgb(255, 0, 0));
    idle(3);
    cycle(1, 0, 0, 8'd0, 8'd0, 8'd0, 0, 24'd0);
    check("pre_reset_clip_cnt", 32'(o_clip_cnt), 32'd1);
    idle(1);
    for (int k = 0; k < 5; k++) px(0, 150, 40, 50, 1, rgb(255, 40, 50));
    rst = 1'b1;
    #1;
    check("async_reset_out", 32'({o_vs, o_hs, o_de, o_b, o_g, o_r}), 32'd0);
    check("async_reset_clip_cnt", 32'(o_clip_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    px(0, 77, 88, 99, 1, rgb(77, 88, 99));
    for (int k = 0; k < 3; k++) px(0, 5 + k, 6 + k, 7 + k, 0, 24'd0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
